// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants, state encoding and helpers for the mul/div sequencer
package proc_pkg;

    // Instruction decode fields: opcode is i_bits[31:27], aluop is i_bits[6:2]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // rstatus codes written downstream when md_exc is raised
    localparam logic [2:0] RSTAT_MUL = 3'd4;
    localparam logic [2:0] RSTAT_DIV = 3'd5;

    // Iteration counter width (counts 0..31)
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Magnitude of a two's-complement 32-bit value; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/x_multdiv_sequencer_if.sv
// rtl/x_multdiv_sequencer_if.sv - D/X-side operand/instruction bus and sequencer status outputs
//
// master: pipeline side (drives instruction, operands, flush; observes stall/result)
// slave : sequencer side
interface x_multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      i_bitsin;
    logic [WIDTH-1:0] data_ain;
    logic [WIDTH-1:0] data_bin;
    logic             flush;
    logic             stall;
    logic             bubble;
    logic             md_valid;
    logic [WIDTH-1:0] md_result;
    logic             md_exc;
    logic             md_is_div;

    modport master (
        output i_bitsin, data_ain, data_bin, flush,
        input  stall, bubble, md_valid, md_result, md_exc, md_is_div
    );

    modport slave (
        input  i_bitsin, data_ain, data_bin, flush,
        output stall, bubble, md_valid, md_result, md_exc, md_is_div
    );
endinterface

// File: rtl/x_multdiv_sequencer_multdiv_iter.sv
// rtl/x_multdiv_sequencer_multdiv_iter.sv - unsigned iterative multiply/divide datapath with sign fix
//
// Ports:
//   clock, reset   : clock, async active-high reset
//   load           : capture magnitudes, sign and op type; clear the accumulator high half
//   step           : perform one shift-add (mul) or restoring subtract-shift (div) iteration
//   is_div         : op type presented with load
//   mag_a, mag_b   : unsigned operand magnitudes presented with load
//   neg            : result must be negated (operand signs differ), presented with load
//   res_next       : sign-fixed 2*WIDTH value of the accumulator after this edge's update
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    input  logic               neg,
    output logic [2*WIDTH-1:0] res_next
);

    // mul: acc = {partial product, remaining multiplier bits}, m = multiplicand
    // div: acc = {partial remainder, dividend bits / quotient bits}, m = divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH+1:0]   diff;

    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        div_d = div_q;
        neg_d = neg_q;
        sum   = '0;
        sh    = '0;
        diff  = '0;

        if (load) begin
            m_d   = is_div ? mag_b : mag_a;
            acc_d = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            div_d = is_div;
            neg_d = neg;
        end else if (step) begin
            if (div_q) begin
                // Shift in the next dividend bit; the partial remainder may briefly
                // need WIDTH+1 bits, so the compare is done one bit wider.
                sh   = {acc_q, 1'b0};
                diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, m_q};
                if (!diff[WIDTH+1]) begin
                    acc_d = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
                end else begin
                    acc_d = sh[2*WIDTH-1:0];
                end
            end else begin
                // Add multiplicand if the current multiplier LSB is set, then shift right
                // keeping the carry.
                sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end

        // Negating the full value also gives the correct low word for a quotient.
        res_next = neg_q ? (~acc_d + 1'b1) : acc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            div_q <= div_d;
            neg_q <= neg_d;
        end
    end

endmodule

// File: rtl/x_multdiv_sequencer.sv
// rtl/x_multdiv_sequencer.sv - execute-stage multi-cycle mul/div sequencer with pipeline stall
//
// Ports:
//   clock, reset : clock, async active-high reset (returns to IDLE)
//   md (slave)   : i_bitsin/data_ain/data_bin/flush in; stall/bubble/md_valid/md_result/
//                  md_exc/md_is_div out
module x_multdiv_sequencer
    import proc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    x_multdiv_sequencer_if.slave   md
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               div_zero_q, div_zero_d;
    logic               div_exc_q, div_exc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               is_md;
    logic               op_div;
    logic               load;
    logic               step;
    logic               last;
    logic               mul_ovf;
    logic [2*WIDTH-1:0] res_next;
    logic [WIDTH:0]     prod_top;

    assign op_div = (md.i_bitsin[6:2] == ALU_DIV);
    assign is_md  = (md.i_bitsin[31:27] == OP_RTYPE) &&
                    ((md.i_bitsin[6:2] == ALU_MUL) || op_div);

    assign load = (state_q == ST_IDLE) && is_md && !md.flush;
    assign step = (state_q == ST_BUSY);
    assign last = step && (count_q == CNT_W'(ITER - 1));

    // Signed product overflows 32 bits unless bits [63:31] are a pure sign extension.
    assign prod_top = res_next[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = !((&prod_top) || !(|prod_top));

    multdiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .is_div   (op_div),
        .mag_a    (abs32(md.data_ain)),
        .mag_b    (abs32(md.data_bin)),
        .neg      (md.data_ain[WIDTH-1] ^ md.data_bin[WIDTH-1]),
        .res_next (res_next)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        div_exc_d  = div_exc_q;
        result_d   = result_q;
        exc_d      = exc_q;

        md.stall     = 1'b0;
        md.md_valid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                md.stall = load;
                if (load) begin
                    state_d    = ST_BUSY;
                    count_d    = '0;
                    is_div_d   = op_div;
                    div_zero_d = (md.data_bin == '0);
                    // Divide by zero and the single overflowing quotient MIN/-1
                    div_exc_d  = (md.data_bin == '0) ||
                                 ((md.data_ain == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                  (md.data_bin == '1));
                end
            end
            ST_BUSY: begin
                md.stall = 1'b1;
                if (last) begin
                    state_d  = ST_DONE;
                    result_d = (is_div_q && div_zero_q) ? '0 : res_next[WIDTH-1:0];
                    exc_d    = is_div_q ? div_exc_q : mul_ovf;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                md.md_valid = 1'b1;
                state_d     = ST_IDLE;
                result_d    = '0;
                exc_d       = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A taken branch/jump kills the op; DONE still shows its result this cycle.
        if (md.flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            if (state_q != ST_DONE) begin
                result_d = '0;
                exc_d    = 1'b0;
            end
        end

        md.bubble    = md.stall;
        md.md_result = result_q;
        md.md_exc    = exc_q;
        md.md_is_div = is_div_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            div_exc_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            div_exc_q  <= div_exc_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
        end
    end

endmodule

// File: tb/tb_x_multdiv_sequencer.sv
// tb/tb_x_multdiv_sequencer.sv - self-checking bench for x_multdiv_sequencer
module tb_x_multdiv_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    x_multdiv_sequencer_if #(.WIDTH(32)) bus ();

    x_multdiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .md    (bus.slave)
    );

    int  checks   = 0;
    int  failures = 0;
    time last_valid_t = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] md_instr(input bit is_div);
        logic [31:0] r;
        r       = $urandom;
        r[31:27] = 5'b00000;
        r[6:2]   = is_div ? 5'b00111 : 5'b00110;
        return r;
    endfunction

    // Random non-md instruction: either a non-R-type opcode or an R-type with another aluop
    function automatic logic [31:0] other_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) begin
            r[31:27] = 5'($urandom_range(1, 31));
        end else begin
            r[31:27] = 5'b00000;
            r[6:2]   = 5'($urandom_range(0, 5));
        end
        return r;
    endfunction

    // Reference: plain signed arithmetic on the architectural values
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint      p;
        logic [63:0] pu;
        logic [32:0] top;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            pu  = p;
            top = pu[63:31];
            res = pu[31:0];
            exc = !((top == 33'd0) || (top == {33{1'b1}}));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = 32'($signed(a) / $signed(b));
            exc = 1'b0;
        end
    endtask

    // chain=0: start from IDLE with the instruction appearing just after an edge.
    // chain=1: called during the previous op's DONE cycle; the new instruction
    //          becomes visible on the following cycle.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit chain, input string tag);
        logic [31:0] er;
        logic        ee;
        int          n;
        int          stall_cycles;
        model(is_div, a, b, er, ee);
        if (!chain) begin
            @(posedge clock);
            #1;
        end
        bus.i_bitsin = md_instr(is_div);
        bus.data_ain = a;
        bus.data_bin = b;
        if (chain) @(posedge clock);
        @(negedge clock);
        chk({tag, " cycle0_stall"}, 64'(bus.stall), 64'd1);
        stall_cycles = bus.stall ? 1 : 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (bus.md_valid === 1'b1) break;
            if (bus.stall === 1'b1) stall_cycles++;
        end
        last_valid_t = $time;
        chk({tag, " latency"},      64'(n),             64'd33);
        chk({tag, " stall_cycles"}, 64'(stall_cycles),  64'd33);
        chk({tag, " done_stall"},   64'({bus.stall, bus.bubble}), 64'd0);
        chk({tag, " result"},       64'(bus.md_result), 64'(er));
        chk({tag, " exc"},          64'(bus.md_exc),    64'(ee));
        chk({tag, " is_div"},       64'(bus.md_is_div), 64'(is_div));
        bus.i_bitsin = other_instr();
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus.md_valid !== 1'b0 || bus.stall !== 1'b0) seen++;
        end
        chk({tag, " quiet"}, 64'(seen), 64'd0);
    endtask

    initial begin
        time t1;
        logic [31:0] ra, rb;
        bit          rd;

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.i_bitsin = other_instr();
        bus.data_ain = '0;
        bus.data_bin = '0;
        #12;
        chk("reset stall",     64'(bus.stall),     64'd0);
        chk("reset bubble",    64'(bus.bubble),    64'd0);
        chk("reset md_valid",  64'(bus.md_valid),  64'd0);
        chk("reset md_result", 64'(bus.md_result), 64'd0);
        chk("reset md_exc",    64'(bus.md_exc),    64'd0);
        chk("reset md_is_div", 64'(bus.md_is_div), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Non-md instructions must never stall or produce a result
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            bus.i_bitsin = other_instr();
            bus.data_ain = $urandom;
            bus.data_bin = $urandom;
            #1;
            chk("nonmd stall", 64'({bus.stall, bus.md_valid}), 64'd0);
        end

        // Directed cases
        run_op(1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        run_op(1'b0, 32'h0001_0000,  32'h0001_0000, 1'b0, "mul_ovf");
        run_op(1'b1, 32'hFFFF_FF9C,  32'd7,         1'b0, "div_m100_7");
        run_op(1'b1, 32'd5,          32'd0,         1'b0, "div_by0");
        run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "div_min_m1");
        run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "mul_min_m1");

        // Back-to-back mul then div
        run_op(1'b0, 32'd12345, 32'hFFFF_F000, 1'b0, "b2b_mul");
        t1 = last_valid_t;
        run_op(1'b1, 32'd1000000, 32'hFFFF_FFF9, 1'b1, "b2b_div");
        chk("b2b spacing", 64'(last_valid_t - t1), 64'd340);

        // Randomized operations
        for (int i = 0; i < 12; i++) begin
            rd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 64)) - 32'd32;
                1: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'($urandom_range(0, 16)) - 32'd8;
                1: rb = 32'd0;
                default: rb = $urandom;
            endcase
            run_op(rd, ra, rb, (i % 3) == 2, "rand");
        end

        // Async reset at BUSY count=10 (cycle 11)
        @(posedge clock);
        #1;
        bus.i_bitsin = md_instr(1'b0);
        bus.data_ain = $urandom;
        bus.data_bin = $urandom;
        repeat (11) @(posedge clock);
        #2;
        reset        = 1'b1;
        bus.i_bitsin = other_instr();
        #1;
        chk("reset_mid stall",    64'(bus.stall),    64'd0);
        chk("reset_mid md_valid", 64'(bus.md_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        watch_no_valid("reset_mid", 40);

        // Flush in cycle 5 of a mul
        @(posedge clock);
        #1;
        bus.i_bitsin = md_instr(1'b0);
        bus.data_ain = 32'd9;
        bus.data_bin = 32'd11;
        repeat (5) @(posedge clock);
        #2;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush    = 1'b0;
        bus.i_bitsin = other_instr();
        chk("flush next stall",    64'(bus.stall),    64'd0);
        chk("flush next md_valid", 64'(bus.md_valid), 64'd0);
        watch_no_valid("flush", 40);

        // Recovery after flush
        run_op(1'b1, 32'hFFFF_FF00, 32'd3, 1'b0, "post_flush_div");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x_multdiv_sequencer.md
# x_multdiv_sequencer

Execute-stage multiply/divide sequencer. It sits beside the ALU between the D/X pipeline register and the X/M pipeline register. It detects `mul`/`div` R-type instructions at the D/X outputs and runs them as fixed 32-iteration sequential operations. While an operation is in flight it stalls the front of the pipeline and bubbles X/M, then presents a registered result and exception flag for one cycle.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `ITER`, 32: iterations per operation; must equal `WIDTH`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; returns block to IDLE.
- `i_bitsin`  in  32  instruction from D/X output.
- `data_ain`  in  32  rs operand from D/X.
- `data_bin`  in  32  rt operand from D/X.
- `flush`  in  1  kill in-flight op (taken branch/jump resolved in X).
- `stall`  out  1  drives low `write_enable` of PC, F/D and D/X registers.
- `bubble`  out  1  forces a nop into X/M this cycle; equals `stall`.
- `md_valid`  out  1  `md_result`/`md_exc` valid this cycle; X/M mux selects them.
- `md_result`  out  32  product low word or quotient.
- `md_exc`  out  1  exception; downstream writes rstatus=4 (mul) or 5 (div).
- `md_is_div`  out  1  latched op type, qualifies `md_exc` code.

## Operation
- Decode: `is_md` = opcode `i_bitsin[31:27]`==00000 and aluop `i_bitsin[6:2]` in {00110 mul, 00111 div}.
- States: IDLE, BUSY, DONE.
- IDLE, `is_md`=1, `flush`=0:
  - `stall`=1 combinationally.
  - On the edge, latch |a|, |b|, sign info and op type; count=0; go to BUSY.
- BUSY:
  - `stall`=1.
  - One iteration per edge: shift-add for mul, restoring subtract-shift for div.
  - When count==ITER-1, go to DONE on that edge; otherwise count+1.
- DONE:
  - `stall`=0, `md_valid`=1, registered result and exception shown.
  - Next edge returns to IDLE. D/X advances on the same edge, so the same instruction is never re-detected.
- `flush`=1 in any state: next state IDLE, no `md_valid`; `stall` follows the normal state rules for the current cycle.
- mul:
  - Signed; result is the low 32 bits of the 64-bit signed product. Sign is applied by two's-complement negation of the unsigned 64-bit product when the operand signs differ.
  - `md_exc`=1 when product bits [63:31] are not all equal.
- div:
  - Signed, quotient truncated toward zero, remainder discarded.
  - Divide by zero: result 0, `md_exc`=1, still takes the full 32 iterations.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, `md_exc`=1.
- Non-md instructions: outputs idle, no effect.
- Reset values: state IDLE, count 0, `stall`=0, `bubble`=0, `md_valid`=0, `md_result`=0, `md_exc`=0, `md_is_div`=0.

## Timing
- Cycle 0: md instruction first visible at D/X, `stall`=1.
- Cycles 1..32: BUSY, `stall`=1.
- Cycle 33: DONE, `md_valid`=1, `stall`=0.
- Total stall 33 cycles; result latency 33 cycles from first visibility.
- Back-to-back md instructions: second detected in cycle 34; no idle gap beyond DONE.
- Reset mid-op: immediate (async) return to IDLE, `stall` drops in the same cycle; partial results are discarded.
- Flush in cycle 0: no stall escapes beyond cycle 0 and no result is produced.
- Flush during DONE: `md_valid` stays 1 for that cycle. The downstream flush logic owns squashing it.

## Structure
- Shared package `proc_pkg`:
  - opcode and aluop constants (`OP_RTYPE`, `ALU_MUL`, `ALU_DIV`).
  - rstatus codes (`RSTAT_MUL`=4, `RSTAT_DIV`=5).
  - state encoding and `CNT_W`=5.
- One sub-module, `multdiv_iter`: unsigned iterative datapath.
  - 64-bit accumulator/remainder with load, step and sign-fix.
  - Sequencer FSM, decode and exception logic stay in the top.

## Test plan
- `mul` a=7, b=-3: `stall` high exactly 33 cycles; cycle 33 `md_valid`=1, `md_result`=0xFFFFFFEB, `md_exc`=0.
- `mul` a=0x00010000, b=0x00010000: `md_result`=0x00000000, `md_exc`=1, `md_is_div`=0.
- `div` a=-100, b=7: `md_result`=0xFFFFFFF2 (-14), `md_exc`=0.
- `div` a=5, b=0: `md_result`=0, `md_exc`=1.
- `div` a=0x80000000, b=-1: `md_result`=0x80000000, `md_exc`=1.
- Control:
  - Assert `reset` at BUSY count=10 → `stall`=0 immediately, no `md_valid`.
  - Then `flush` in cycle 5 of a `mul` → IDLE next cycle, no `md_valid`.
  - Back-to-back `mul`, `div` → two `md_valid` pulses 34 cycles apart.
